// File: rtl/alu_multiword_seq.sv
// rtl/alu_multiword_seq.sv - drives an n-bit combinational ALU one word at a time for W = n*K-bit operations
// Arithmetic modes are folded onto ALU addition with carry chaining; bitwise modes pass straight through.
module alu_multiword_seq #(
    parameter int n = 4,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2:0]     Mode,
    input  logic [n*K-1:0] A_in,
    input  logic [n*K-1:0] B_in,
    input  logic           CB_in,
    output logic           busy,
    output logic           done,
    output logic [n*K-1:0] Result_out,
    output logic           CB_final,
    output logic [n-1:0]   alu_A,
    output logic [n-1:0]   alu_B,
    output logic           alu_CB_in,
    output logic [2:0]     alu_Mode,
    input  logic [n-1:0]   alu_Result,
    input  logic           alu_CB_out
);
    localparam int W    = n * K;
    localparam int IDXW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);

    localparam logic [2:0] M_ADD = 3'b000;
    localparam logic [2:0] M_SUB = 3'b001;
    localparam logic [2:0] M_INC = 3'b110;
    localparam logic [2:0] M_DEC = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [2:0]      mode_reg;
    logic            carry;
    logic            accept;
    logic            last;
    logic            arith;
    logic            invert_cb;
    logic            init_carry;
    logic [n-1:0]    a_word;
    logic [n-1:0]    b_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last      = (state == RUN) && (idx == LAST_IDX);
    assign arith     = (mode_reg == M_ADD) || (mode_reg == M_SUB) ||
                       (mode_reg == M_INC) || (mode_reg == M_DEC);
    // Subtract and decrement run as additions, so their carry out is an inverted borrow.
    assign invert_cb = (mode_reg == M_SUB) || (mode_reg == M_DEC);
    assign a_word    = a_reg[int'(idx) * n +: n];
    assign b_word    = b_reg[int'(idx) * n +: n];

    always_comb begin
        init_carry = 1'b0;
        case (Mode)
            M_ADD:   init_carry = CB_in;
            M_SUB:   init_carry = ~CB_in;
            M_INC:   init_carry = 1'b1;
            default: init_carry = 1'b0;
        endcase
    end

    always_comb begin
        alu_A     = '0;
        alu_B     = '0;
        alu_CB_in = 1'b0;
        alu_Mode  = M_ADD;
        if (state == RUN) begin
            alu_A = a_word;
            case (mode_reg)
                M_ADD: begin
                    alu_B     = b_word;
                    alu_CB_in = carry;
                end
                M_SUB: begin
                    alu_B     = ~b_word;
                    alu_CB_in = carry;
                end
                M_INC: begin
                    alu_B     = '0;
                    alu_CB_in = carry;
                end
                M_DEC: begin
                    alu_B     = '1;
                    alu_CB_in = carry;
                end
                default: begin
                    alu_B    = b_word;
                    alu_Mode = mode_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            carry      <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            mode_reg   <= M_ADD;
            Result_out <= '0;
            CB_final   <= 1'b0;
        end else if (accept) begin
            a_reg    <= A_in;
            b_reg    <= B_in;
            mode_reg <= Mode;
            idx      <= '0;
            carry    <= init_carry;
        end else if (state == RUN) begin
            Result_out[int'(idx) * n +: n] <= alu_Result;
            carry <= alu_CB_out;
            idx   <= last ? '0 : idx + IDXW'(1);
            if (last) begin
                CB_final <= arith & (alu_CB_out ^ invert_cb);
            end
        end
    end
endmodule

// File: tb/tb_alu_multiword_seq.sv
// tb/tb_alu_multiword_seq.sv - self-checking bench for alu_multiword_seq with an attached ALU model
module tb_alu_multiword_seq;
    localparam int n = 4;
    localparam int K = 4;
    localparam int W = n * K;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   Mode;
    logic [W-1:0] A_in;
    logic [W-1:0] B_in;
    logic         CB_in;
    logic         busy;
    logic         done;
    logic [W-1:0] Result_out;
    logic         CB_final;
    logic [n-1:0] alu_A;
    logic [n-1:0] alu_B;
    logic         alu_CB_in;
    logic [2:0]   alu_Mode;
    logic [n-1:0] alu_Result;
    logic         alu_CB_out;
    logic [n:0]   alu_t;

    int checks = 0;
    int errors = 0;

    logic [n-1:0] obs_a    [0:K+3];
    logic [n-1:0] obs_b    [0:K+3];
    logic [2:0]   obs_mode [0:K+3];
    logic         obs_cbin [0:K+3];
    int           obs_cnt;

    alu_multiword_seq #(.n(n), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Mode(Mode),
        .A_in(A_in), .B_in(B_in), .CB_in(CB_in),
        .busy(busy), .done(done), .Result_out(Result_out), .CB_final(CB_final),
        .alu_A(alu_A), .alu_B(alu_B), .alu_CB_in(alu_CB_in), .alu_Mode(alu_Mode),
        .alu_Result(alu_Result), .alu_CB_out(alu_CB_out)
    );

    always #5 clk = ~clk;

    // Combinational n-bit ALU standing in for the real one.
    always_comb begin
        alu_t = '0;
        case (alu_Mode)
            3'b000: alu_t = {1'b0, alu_A} + {1'b0, alu_B} + {{n{1'b0}}, alu_CB_in};
            3'b001: alu_t = {1'b0, alu_A} - {1'b0, alu_B} - {{n{1'b0}}, alu_CB_in};
            3'b010: alu_t = {1'b0, alu_A & alu_B};
            3'b011: alu_t = {1'b0, alu_A | alu_B};
            3'b100: alu_t = {1'b0, alu_A ^ alu_B};
            3'b101: alu_t = {1'b0, ~alu_A};
            3'b110: alu_t = {1'b0, alu_A} + 1'b1;
            default: alu_t = {1'b0, alu_A} - 1'b1;
        endcase
        alu_Result = alu_t[n-1:0];
        alu_CB_out = alu_t[n];
    end

    function automatic void ref_op(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cb, output logic [W-1:0] r, output logic c);
        logic [W:0] t;
        c = 1'b0;
        case (m)
            3'd0: begin t = {1'b0, a} + {1'b0, b} + cb; r = t[W-1:0]; c = t[W]; end
            3'd1: begin r = a - b - cb; c = ({1'b0, a} < ({1'b0, b} + cb)); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = a + 1'b1; c = (a == {W{1'b1}}); end
            default: begin r = a - 1'b1; c = (a == '0); end
        endcase
    endfunction

    task automatic do_op(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cb, output logic [W-1:0] r, output logic c,
                         output int edges, output logic pulse_ok);
        @(negedge clk);
        start = 1'b1; Mode = m; A_in = a; B_in = b; CB_in = cb;
        @(negedge clk);
        start = 1'b0; Mode = 3'($urandom); A_in = W'($urandom); B_in = W'($urandom); CB_in = 1'($urandom);
        edges = 0;
        obs_cnt = 0;
        while (!done && edges < 20) begin
            if (busy && obs_cnt < K + 4) begin
                obs_a[obs_cnt] = alu_A; obs_b[obs_cnt] = alu_B;
                obs_mode[obs_cnt] = alu_Mode; obs_cbin[obs_cnt] = alu_CB_in;
                obs_cnt++;
            end
            @(negedge clk);
            edges++;
        end
        r = Result_out;
        c = CB_final;
        @(negedge clk);
        pulse_ok = !done && !busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; Mode = 3'b000; A_in = '0; B_in = '0; CB_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, CB_final} !== 3'b000 || Result_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b res=%h cb=%b want 0", busy, done, Result_out, CB_final);
        end
        checks++;
        if (alu_A !== '0 || alu_B !== '0 || alu_CB_in !== 1'b0 || alu_Mode !== 3'b000) begin
            errors++;
            $display("FAIL reset_alu_idle: A=%h B=%h cin=%b mode=%b want 0", alu_A, alu_B, alu_CB_in, alu_Mode);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [W-1:0] r; logic c; int e; logic p;
        do_op(3'b000, 16'hFFFF, 16'h0001, 1'b0, r, c, e, p);
        checks++;
        if (r !== 16'h0000 || c !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: res=%h cb=%b want 0000 1", r, c);
        end
        checks++;
        if (e !== K || !p) begin
            errors++;
            $display("FAIL add_latency: edges=%0d pulse_ok=%b want %0d 1", e, p, K);
        end
        checks++;
        if (alu_A !== '0 || alu_B !== '0 || alu_CB_in !== 1'b0 || alu_Mode !== 3'b000) begin
            errors++;
            $display("FAIL idle_alu_after_op: A=%h B=%h cin=%b mode=%b want 0", alu_A, alu_B, alu_CB_in, alu_Mode);
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] av [2] = '{16'h1000, 16'h0000};
        logic [W-1:0] rv [2] = '{16'h0FFF, 16'hFFFF};
        logic         cv [2] = '{1'b0, 1'b1};
        logic [W-1:0] r; logic c; int e; logic p;
        for (int t = 0; t < 2; t++) begin
            do_op(3'b001, av[t], 16'h0001, 1'b0, r, c, e, p);
            checks++;
            if (r !== rv[t] || c !== cv[t]) begin
                errors++;
                $display("FAIL sub_%0d: res=%h cb=%b want %h %b", t, r, c, rv[t], cv[t]);
            end
            checks++;
            if (obs_cnt !== K) begin
                errors++;
                $display("FAIL sub_run_cycles_%0d: got %0d want %0d", t, obs_cnt, K);
            end
            for (int i = 0; i < K; i++) begin
                logic [W-1:0] bw;
                bw = 16'h0001 >> (i * n);
                checks++;
                if (obs_mode[i] !== 3'b000 || obs_b[i] !== ~bw[n-1:0]) begin
                    errors++;
                    $display("FAIL sub_alu_word_%0d_%0d: mode=%b B=%h want 000 %h", t, i, obs_mode[i], obs_b[i], ~bw[n-1:0]);
                end
            end
        end
    endtask

    task automatic test_inc_dec();
        logic [2:0]   mv [3] = '{3'b110, 3'b111, 3'b111};
        logic [W-1:0] av [3] = '{16'hFFFF, 16'h0000, 16'h0100};
        logic [W-1:0] rv [3] = '{16'h0000, 16'hFFFF, 16'h00FF};
        logic         cv [3] = '{1'b1, 1'b1, 1'b0};
        logic [W-1:0] r; logic c; int e; logic p;
        for (int t = 0; t < 3; t++) begin
            do_op(mv[t], av[t], W'($urandom), 1'($urandom), r, c, e, p);
            checks++;
            if (r !== rv[t] || c !== cv[t]) begin
                errors++;
                $display("FAIL incdec_%0d: res=%h cb=%b want %h %b", t, r, c, rv[t], cv[t]);
            end
        end
    endtask

    task automatic test_bitwise();
        logic [W-1:0] r; logic c; int e; logic p;
        do_op(3'b100, 16'hA5A5, 16'h0FF0, 1'b1, r, c, e, p);
        checks++;
        if (r !== 16'hAA55 || c !== 1'b0) begin
            errors++;
            $display("FAIL xor: res=%h cb=%b want aa55 0", r, c);
        end
        do_op(3'b101, 16'h1234, 16'hFFFF, 1'b1, r, c, e, p);
        checks++;
        if (r !== 16'hEDCB || c !== 1'b0) begin
            errors++;
            $display("FAIL not: res=%h cb=%b want edcb 0", r, c);
        end
        for (int i = 0; i < K; i++) begin
            checks++;
            if (obs_cbin[i] !== 1'b0 || obs_mode[i] !== 3'b101) begin
                errors++;
                $display("FAIL not_alu_word_%0d: cin=%b mode=%b want 0 101", i, obs_cbin[i], obs_mode[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, r, er; logic cb, c, ec; logic [2:0] m; int e; logic p;
        for (int t = 0; t < 40; t++) begin
            m = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom); cb = 1'($urandom);
            if (t % 8 == 0) a = '0;
            if (t % 8 == 1) a = '1;
            ref_op(m, a, b, cb, er, ec);
            do_op(m, a, b, cb, r, c, e, p);
            checks++;
            if (r !== er || c !== ec || e !== K || !p) begin
                errors++;
                $display("FAIL random_%0d: mode=%0d a=%h b=%h cb=%b res=%h cbf=%b edges=%0d want %h %b %0d",
                         t, m, a, b, cb, r, c, e, er, ec, K);
            end
            for (int i = 0; i < obs_cnt; i++) begin
                logic [2:0] em;
                em = (m == 3'd0 || m == 3'd1 || m == 3'd6 || m == 3'd7) ? 3'b000 : m;
                checks++;
                if (obs_mode[i] !== em || obs_a[i] !== n'(a >> (i * n))) begin
                    errors++;
                    $display("FAIL random_alu_%0d_%0d: mode=%b A=%h want %b %h", t, i, obs_mode[i], obs_a[i], em, n'(a >> (i * n)));
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        int t;
        @(negedge clk);
        start = 1'b1; Mode = 3'b000; A_in = 16'h1111; B_in = 16'h2222; CB_in = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; Mode = 3'b001; A_in = 16'hFFFF; B_in = 16'hFFFF; CB_in = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL ignore_done_timeout: done=%b want 1", done);
        end
        start = 1'b1; Mode = 3'b100; A_in = 16'hAAAA;
        @(negedge clk); start = 1'b0;
        checks++;
        if (Result_out !== 16'h3333 || CB_final !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: res=%h cb=%b busy=%b want 3333 0 0", Result_out, CB_final, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || Result_out !== 16'h3333) begin
            errors++;
            $display("FAIL ignore_no_accept: busy=%b res=%h want 0 3333", busy, Result_out);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] a, b, r, er; logic c, ec; int e; logic p;
        @(negedge clk);
        start = 1'b1; Mode = 3'b000; A_in = 16'h1234; B_in = 16'h1111; CB_in = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, CB_final} !== 3'b000 || Result_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b res=%h cb=%b want 0", busy, done, Result_out, CB_final);
        end
        checks++;
        if (alu_A !== '0 || alu_B !== '0 || alu_CB_in !== 1'b0 || alu_Mode !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_run_alu: A=%h B=%h cin=%b mode=%b want 0", alu_A, alu_B, alu_CB_in, alu_Mode);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = W'($urandom); b = W'($urandom);
        ref_op(3'b000, a, b, 1'b1, er, ec);
        do_op(3'b000, a, b, 1'b1, r, c, e, p);
        checks++;
        if (r !== er || c !== ec || e !== K) begin
            errors++;
            $display("FAIL after_reset_add: res=%h cb=%b edges=%0d want %h %b %0d", r, c, e, er, ec, K);
        end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        int t;
        logic [W-1:0] er; logic ec;
        ref_op(3'b001, 16'h8000, 16'h9001, 1'b1, er, ec);
        @(negedge clk);
        start = 1'b1; Mode = 3'b001; A_in = 16'h8000; B_in = 16'h9001; CB_in = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (done) begin
                dq.push_back(cyc);
                checks++;
                if (Result_out !== er || CB_final !== ec) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: res=%h cb=%b want %h %b", cyc, Result_out, CB_final, er, ec);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (dq.size() < 4 || dq[0] !== K) begin
            errors++;
            $display("FAIL b2b_count: dones=%0d first=%0d want >=4 %0d", dq.size(), (dq.size() > 0) ? dq[0] : -1, K);
        end
        for (int i = 1; i < dq.size(); i++) begin
            checks++;
            if (dq[i] - dq[i-1] !== K + 2) begin
                errors++;
                $display("FAIL b2b_spacing_%0d: got %0d want %0d", i, dq[i] - dq[i-1], K + 2);
            end
        end
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_inc_dec();
        test_bitwise();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
